timer_sched: RTL

- Four-channel centisecond countdown scheduler on the 6502 bus, memory-mapped like the other nano6502 peripherals.
- One shared prescaler generates a 10 ms tick that all channels consume.
- Each channel is started or stopped by the CPU, runs one-shot or periodic, and raises a per-channel expiry flag.
- Enabled flags are combined into a single level interrupt for the CPU IRQ line.

---
 rtl/timer_sched_pkg.sv | 13 +
 rtl/timer_sched_chan.sv | 55 +++++
 rtl/timer_sched.sv | 76 +++++++
 3 files changed

// File: rtl/timer_sched_pkg.sv
// timer_sched_pkg: register map, channel state encoding and channel count for timer_sched.
package timer_sched_pkg;
    localparam int NUM_CH = 4;
    localparam logic [2:0] ADDR_STATUS    = 3'd0;
    localparam logic [2:0] ADDR_START     = 3'd1;
    localparam logic [2:0] ADDR_STOP      = 3'd2;
    localparam logic [2:0] ADDR_FLAGS     = 3'd3;
    localparam logic [2:0] ADDR_CTRL      = 3'd4;
    localparam logic [2:0] ADDR_SEL       = 3'd5;
    localparam logic [2:0] ADDR_RELOAD_LO = 3'd6;
    localparam logic [2:0] ADDR_RELOAD_HI = 3'd7;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} chan_state_e;
endpackage

// File: rtl/timer_sched_chan.sv
// timer_sched_chan: one countdown channel (IDLE/RUN FSM, 16-bit count, reload register).
// rd_val is the live count when TIMER_SCHED_READCNT_EN is defined, otherwise the reload value.
module timer_sched_chan
    import timer_sched_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        tick,
    input  logic        start,
    input  logic        stop,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        periodic,
    input  logic [7:0]  wdata,
    output logic        idle,
    output logic        expire,
    output logic [15:0] rd_val
);
    chan_state_e state_q, state_d;
    logic [15:0] count_q, count_d, reload_q;
    logic hit;
    // A zero count (reload of 0) expires without waiting for a tick.
    assign hit    = state_q == RUN && (count_q == '0 || (tick && count_q == 16'd1));
    assign expire = hit && !start && !stop;
    assign idle   = state_q == IDLE;
`ifdef TIMER_SCHED_READCNT_EN
    assign rd_val = count_q;
`else
    assign rd_val = reload_q;
`endif
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (wr_lo) reload_q[7:0] <= wdata;
            if (wr_hi) reload_q[15:8] <= wdata;
        end
    end
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (stop) state_d = IDLE;
        else if (start) begin
            state_d = RUN;
            count_d = reload_q;
        end else if (hit) begin
            if (periodic) count_d = reload_q;
            else state_d = IDLE;
        end else if (state_q == RUN && tick) count_d = count_q - 16'd1;
    end
endmodule

// File: rtl/timer_sched.sv
// timer_sched: four-channel 10 ms countdown scheduler on the 6502 bus with a level IRQ.
// Define TIMER_SCHED_READCNT_EN to make addr 6/7 read the live count instead of the reload.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int CLK_FRE  = 25_175_000,
    parameter int TICK_DIV = CLK_FRE / 100
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       R_W_n,
    input  logic [2:0] reg_addr_i,
    input  logic [7:0] data_i,
    input  logic       sched_cs,
    output logic [7:0] data_o,
    output logic       irq_o
);
    localparam logic [17:0] TICK_MAX = 18'(TICK_DIV - 1);
    logic [17:0] presc_q;
    logic [NUM_CH-1:0] flags_q, idle, expire, clr;
    logic [7:0] ctrl_q;
    logic [1:0] sel_q;
    logic [15:0] rd_val [NUM_CH];
    logic tick, wr, wr_start, wr_stop, wr_lo, wr_hi;
    assign tick     = presc_q == TICK_MAX;
    assign wr       = sched_cs && !R_W_n;
    assign wr_start = wr && reg_addr_i == ADDR_START;
    assign wr_stop  = wr && reg_addr_i == ADDR_STOP;
    assign wr_lo    = wr && reg_addr_i == ADDR_RELOAD_LO;
    assign wr_hi    = wr && reg_addr_i == ADDR_RELOAD_HI;
    assign clr      = wr && reg_addr_i == ADDR_FLAGS ? data_i[NUM_CH-1:0] : '0;
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc_q <= '0;
            flags_q <= '0;
            ctrl_q  <= '0;
            sel_q   <= '0;
            irq_o   <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 18'd1;
            // A new expiry beats a W1C clear of the same bit.
            flags_q <= (flags_q & ~clr) | expire;
            irq_o   <= |(flags_q & ctrl_q[NUM_CH-1:0]);
            if (wr && reg_addr_i == ADDR_CTRL) ctrl_q <= data_i;
            if (wr && reg_addr_i == ADDR_SEL) sel_q <= data_i[1:0];
        end
    end
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_sched_chan u_chan (
            .clk_i,
            .rst_n_i,
            .tick,
            .start   (wr_start && data_i[i]),
            .stop    (wr_stop && data_i[i]),
            .wr_lo   (wr_lo && sel_q == 2'(i)),
            .wr_hi   (wr_hi && sel_q == 2'(i)),
            .periodic(ctrl_q[NUM_CH+i]),
            .wdata   (data_i),
            .idle    (idle[i]),
            .expire  (expire[i]),
            .rd_val  (rd_val[i])
        );
    end
    always_comb begin
        data_o = '0;
        case (reg_addr_i)
            ADDR_STATUS:    data_o = {4'h0, idle};
            ADDR_FLAGS:     data_o = {4'h0, flags_q};
            ADDR_CTRL:      data_o = ctrl_q;
            ADDR_SEL:       data_o = {6'd0, sel_q};
            ADDR_RELOAD_LO: data_o = rd_val[sel_q][7:0];
            ADDR_RELOAD_HI: data_o = rd_val[sel_q][15:8];
            default:        data_o = '0;
        endcase
    end
endmodule
